// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and frame constants shared by the UART transmit and receive paths.
package uart_pkg;
    localparam int DATA_BITS = 8;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/sipo_rx.sv
// sipo_rx: serial-in/parallel-out shifter; bits enter at the MSB so the first (LSB-first) bit lands in bit 0.
module sipo_rx
    import uart_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_shift,
    input  logic                 i_serialdata,
    output logic [DATA_BITS-1:0] o_dataout
);
    logic [DATA_BITS-1:0] shreg_q;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) shreg_q <= '0;
        else if (i_shift) shreg_q <= {i_serialdata, shreg_q[DATA_BITS-1:1]};

    assign o_dataout = shreg_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver; synchronizes the line, samples each bit at its centre and emits a byte with valid/framing-error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_serialdata,
    output logic [DATA_BITS-1:0] o_dataout,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] data_q, data_d, shreg;
    logic                 valid_q, valid_d, ferr_q, ferr_d;
    logic                 rx_meta_q, rx_s_q, rx_prev_q, shift;

    sipo_rx u_sipo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_shift      (shift),
        .i_serialdata (rx_s_q),
        .o_dataout    (shreg)
    );

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            {rx_meta_q, rx_s_q, rx_prev_q} <= 3'b111;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            {rx_meta_q, rx_s_q, rx_prev_q} <= {i_serialdata, rx_meta_q, rx_s_q};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end

    // cnt clears at every sampling point, so it never has to wrap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        data_d  = data_q;
        shift   = 1'b0;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = (rx_prev_q && !rx_s_q) ? START : IDLE;
            end
            START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s_q ? IDLE : DATA;
            end
            DATA: if (cnt_q == LAST) begin
                cnt_d   = '0;
                shift   = 1'b1;
                idx_d   = idx_q + IW'(1);
                state_d = (idx_q == IW'(DATA_BITS - 1)) ? STOP : DATA;
            end
            STOP: if (cnt_q == LAST) begin
                cnt_d   = '0;
                state_d = IDLE;
                valid_d = rx_s_q;
                ferr_d  = !rx_s_q;
                data_d  = rx_s_q ? shreg : data_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_dataout   = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; frames push expected events, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_uart_rx;
    logic       clk = 1'b0, rst_n = 1'b0, rx_line = 1'b1;
    logic [7:0] o_dataout;
    logic       o_valid, o_frame_err, o_busy;
    int         cyc = 0, n_cmp = 0, n_bad = 0;
    logic [7:0] last_good = 8'h00;

    typedef struct {logic err; logic [7:0] data; int at;} ev_t;
    ev_t exp_q[$];
    ev_t e;

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_serialdata (rx_line),
        .o_dataout    (o_dataout),
        .o_valid      (o_valid),
        .o_frame_err  (o_frame_err),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rst_n && (o_valid || o_frame_err)) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_event: valid=%b frame_err=%b data=%h cycle=%0d, required no event", o_valid, o_frame_err, o_dataout, cyc);
            end else begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({o_frame_err, o_valid} !== {e.err, !e.err}) begin
                    n_bad++;
                    $display("FAIL event_kind: err,valid=%b%b required %b%b", o_frame_err, o_valid, e.err, !e.err);
                end
                n_cmp++;
                if (o_dataout !== e.data) begin
                    n_bad++;
                    $display("FAIL event_data: got %h required %h", o_dataout, e.data);
                end
                if (e.at >= 0) begin
                    n_cmp++;
                    if (cyc !== e.at) begin
                        n_bad++;
                        $display("FAIL event_time: cycle %0d required %0d", cyc, e.at);
                    end
                end
            end
        end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int per, input logic timed);
        int t0 = cyc;
        if (stop) begin
            exp_q.push_back('{1'b0, b, timed ? t0 + 155 : -1});
            last_good = b;
        end else exp_q.push_back('{1'b1, last_good, timed ? t0 + 155 : -1});
        rx_line = 1'b0;
        #(per);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            #(per);
        end
        rx_line = stop;
        #(per);
    endtask

    task automatic settle_and_check(input string name, input logic [7:0] want);
        rx_line = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_missing: %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        n_cmp++;
        if (o_dataout !== want) begin
            n_bad++;
            $display("FAIL %s_dataout: got %h required %h", name, o_dataout, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({o_dataout, o_valid, o_frame_err, o_busy} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: data=%h v=%b fe=%b busy=%b required all 0", o_dataout, o_valid, o_frame_err, o_busy);
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_single();
        align();
        send_frame(8'hA5, 1'b1, 160, 1'b1);
        settle_and_check("single", 8'hA5);
    endtask

    task automatic test_back_to_back();
        align();
        send_frame(8'h00, 1'b1, 160, 1'b1);
        send_frame(8'hFF, 1'b1, 160, 1'b1);
        settle_and_check("b2b", 8'hFF);
    endtask

    task automatic test_glitch();
        int busy_cnt = 0;
        align();
        rx_line = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_line = 1'b1;
        repeat (30) @(negedge clk) busy_cnt += int'(o_busy);
        n_cmp++;
        if (busy_cnt < 1 || busy_cnt > 8) begin
            n_bad++;
            $display("FAIL glitch_busy: busy cycles %0d required 1..8", busy_cnt);
        end
        align();
        send_frame(8'h3C, 1'b1, 160, 1'b1);
        settle_and_check("glitch_next", 8'h3C);
    endtask

    task automatic test_frame_err();
        align();
        send_frame(8'h96, 1'b1, 160, 1'b1);
        send_frame(8'h3C, 1'b0, 160, 1'b1);
        #(40 * 160);
        n_cmp++;
        if (o_busy !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL ferr_hold: busy=%b pending=%0d required busy=0 pending=0", o_busy, exp_q.size());
            exp_q.delete();
        end
        n_cmp++;
        if (o_dataout !== 8'h96) begin
            n_bad++;
            $display("FAIL ferr_keep: got %h required 96", o_dataout);
        end
        rx_line = 1'b1;
        repeat (20) @(posedge clk);
        align();
        send_frame(8'h81, 1'b1, 160, 1'b1);
        settle_and_check("ferr_next", 8'h81);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b = 8'h77;
        align();
        rx_line = 1'b0;
        #160;
        for (int i = 0; i < 4; i++) begin
            rx_line = b[i];
            #160;
        end
        rx_line = b[4];
        #80;
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({o_dataout, o_valid, o_frame_err, o_busy} !== 11'h0) begin
            n_bad++;
            $display("FAIL midreset_outputs: data=%h v=%b fe=%b busy=%b required all 0", o_dataout, o_valid, o_frame_err, o_busy);
        end
        rx_line = 1'b1;
        last_good = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        align();
        send_frame(8'h5A, 1'b1, 160, 1'b1);
        settle_and_check("midreset_next", 8'h5A);
    endtask

    task automatic test_skew();
        align();
        send_frame(8'h55, 1'b1, 155, 1'b0);
        settle_and_check("skew_fast", 8'h55);
        repeat (10) @(posedge clk);
        align();
        send_frame(8'hC3, 1'b1, 165, 1'b0);
        settle_and_check("skew_slow", 8'hC3);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_skew();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
